cdb_arbiter: RTL
================

# cdb_arbiter

Arbitrates the common data bus (CDB) between the two writeback producers, the ALU and the load/store buffer. Each producer pushes results into a private FIFO, and the block grants one result per cycle onto a single registered CDB. The CDB feeds the reorder buffer, the reservation station and the load/store buffer. Producers keep firing even when both complete in the same cycle, and the downstream consumers see exactly one writeback port.

## Interface
Parameters:
- ROB_SIZE_BIT, default 4: width of a ROB index.
- FIFO_DEPTH, default 4: entries per requester FIFO. Must be a power of 2 and at least 2.

Ports:
- clk_in, input, 1: the single clock.
- rst_in, input, 1: asynchronous, active-low reset.
- rdy_in, input, 1: global stall when low.
- rob_clear, input, 1: misprediction flush.
- alu_valid, input, 1: ALU result present this cycle.
- alu_rob_idx, input, ROB_SIZE_BIT: ROB entry of the ALU result.
- alu_value, input, 32: ALU result value.
- alu_ready, output, 1: the ALU FIFO can accept a result.
- lsb_valid, input, 1: load result present this cycle.
- lsb_rob_idx, input, ROB_SIZE_BIT: ROB entry of the load result.
- lsb_value, input, 32: load result value.
- lsb_ready, output, 1: the LSB FIFO can accept a result.
- cdb_valid, output, 1: CDB broadcast is valid.
- cdb_rob_idx, output, ROB_SIZE_BIT: broadcast ROB index.
- cdb_value, output, 32: broadcast value.
- cdb_src, output, 1: source of the broadcast; 0 = ALU, 1 = LSB.

## Operation
- Push rule: a requester's result is accepted when `x_valid && x_ready && rdy_in && !rob_clear`.
  - `x_valid` while `x_ready` is low is a protocol violation. The result is dropped, and the bench flags it.
- Ready: `x_ready = (count_x != FIFO_DEPTH)`. It is derived from registered state only. There is no pop-through on a full FIFO.
- Arbitration state:
  - One round-robin register, last_grant: 0 = ALU, 1 = LSB.
  - Reset value is 1, so the ALU wins the first tie.
- Grant each cycle (rdy_in high, no clear):
  - Both FIFOs non-empty: grant the FIFO opposite to last_grant, then update last_grant.
  - Exactly one FIFO non-empty: grant it and update last_grant.
  - Neither FIFO non-empty: no grant. cdb_valid goes to 0 at the edge.
- Output register:
  - On a grant, the head entry is popped and loaded into {cdb_rob_idx, cdb_value, cdb_src}, with cdb_valid = 1.
  - The CDB is valid for exactly one cycle per grant and is never held.
- Counters and pointers:
  - Per-FIFO rd_ptr and wr_ptr are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits wide.
  - A simultaneous push and pop leaves count unchanged.
- rob_clear (sampled only while rdy_in is high):
  - At the edge, both counts and pointers return to 0 and cdb_valid goes to 0.
  - Requests presented in the same cycle are dropped.
  - last_grant returns to 1.
- rdy_in low: all state is frozen. Outputs hold their values, pushes are ignored, and alu_ready and lsb_ready still reflect the frozen counts.
- Reset (asynchronous assert, synchronous release):
  - cdb_valid = 0, cdb_rob_idx = 0, cdb_value = 0, cdb_src = 0.
  - alu_ready = 1 and lsb_ready = 1.
  - FIFOs empty, last_grant = 1.

## Timing
- Baseline latency, bypass compiled out:
  - A result accepted at edge E0 enters its FIFO.
  - The earliest broadcast is cdb_valid high during the cycle after E1, i.e. 2 edges.
- Sustained throughput is 1 broadcast per cycle.
- Under continuous dual load, the grants alternate ALU, LSB, ALU, and so on.
- Worst-case wait for a queued entry is 2×FIFO_DEPTH−1 grants.
- The ready deassert takes effect in the cycle after the push that fills the FIFO.

## Configuration
- CDB_BYPASS_EN defined:
  - A result accepted at E0 by an empty FIFO skips the FIFO storage.
  - It is loaded directly into the output register at E0 when it would win arbitration that cycle under the same round-robin rule, with both requesters eligible on arrival.
  - Latency becomes 1 edge.
  - The loser of a bypass tie is written into its FIFO.
- CDB_BYPASS_EN undefined: every result passes through its FIFO, with the fixed 2-edge latency.

## Structure
- Shared package cdb_pkg:
  - ROB_SIZE_BIT.
  - CDB source encoding: CDB_SRC_ALU = 0, CDB_SRC_LSB = 1.
  - The packed CDB entry type: rob_idx plus value.
- Sub-module cdb_fifo: parameterised FIFO_DEPTH, with push, pop, flush, head output, count and full. It is instantiated twice.
- Arbitration and the output register live in cdb_arbiter.

## Test plan
- Single ALU push: idx 3, value 0x0000_00AA at E0.
  - Expect cdb_valid with {3, 0xAA, src 0} after E1.
  - With CDB_BYPASS_EN, expect it after E0.
- Simultaneous push from reset: ALU {1, 0x11} and LSB {2, 0x22} in the same cycle.
  - Expect broadcast ALU then LSB on consecutive cycles, then cdb_valid = 0.
- Fill: hold lsb_valid for 4 cycles while the ALU is also streaming, with FIFO_DEPTH = 4.
  - Expect lsb_ready to drop after the 4th push only if the pops lag.
  - Expect broadcasts to strictly alternate sources.
  - Expect no entry lost or duplicated, checked against a scoreboard with 100 random entries.
- rob_clear with 3 entries queued per FIFO and cdb_valid high:
  - Expect cdb_valid = 0 the next cycle, both readys = 1, and no stale idx ever broadcast.
  - Expect the next push to be broadcast with its own value.
- rdy_in low for 5 cycles with entries queued and pushes asserted:
  - Expect outputs and counts frozen and pushes ignored.
  - Expect broadcasting to resume in the same order after rdy_in returns.
- Async reset asserted mid-stream, between edges:
  - Expect the outputs to go to their reset values immediately.
  - Expect the first post-reset tie to be granted to the ALU.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared definitions for the common data bus arbiter.
//   ROB_SIZE_BIT - default width of a reorder buffer index
//   CDB_VALUE_W  - width of a broadcast result value
//   CDB_SRC_ALU / CDB_SRC_LSB - encoding of cdb_src
//   cdb_entry_t  - packed CDB payload {rob_idx, value} at the default width
package cdb_pkg;

    localparam int ROB_SIZE_BIT = 4;
    localparam int CDB_VALUE_W  = 32;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    typedef struct packed {
        logic [ROB_SIZE_BIT-1:0] rob_idx;
        logic [CDB_VALUE_W-1:0]  value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-requester result queue in front of the CDB arbiter.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - global advance; all state frozen while low
//   push, push_data - enqueue one entry (caller guarantees !full)
//   pop             - dequeue the head entry (caller guarantees non-empty)
//   flush           - empty the queue (takes priority over push/pop)
//   head            - entry at the read pointer (combinational)
//   count, full     - occupancy and full flag, from registered state only
module cdb_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 36
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             push_data,
    output logic [DATA_W-1:0]             head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries data only; no reset needed.
    always_ff @(posedge clk) begin
        if (en && push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
    assign full = (count == DEPTH_CNT);

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and load/store results onto one registered CDB.
// Each producer feeds a private cdb_fifo; a round-robin grant pops one head
// per cycle into the output register, which is valid for exactly one cycle.
// Optional feature macro: CDB_BYPASS_EN - a result arriving at an empty FIFO
// that wins arbitration on arrival is loaded straight into the output
// register, giving 1-edge latency instead of 2.
// Ports:
//   clk_in, rst_in      - clock, asynchronous active-low reset
//   rdy_in              - global stall when low (all state frozen)
//   rob_clear           - flush queues and output valid (sampled when rdy_in)
//   alu_valid/rob_idx/value, alu_ready - ALU result push interface
//   lsb_valid/rob_idx/value, lsb_ready - load result push interface
//   cdb_valid, cdb_rob_idx, cdb_value, cdb_src - registered CDB broadcast
module cdb_arbiter #(
    parameter int ROB_SIZE_BIT = cdb_pkg::ROB_SIZE_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
    input  logic [31:0]             alu_value,
    output logic                    alu_ready,
    input  logic                    lsb_valid,
    input  logic [ROB_SIZE_BIT-1:0] lsb_rob_idx,
    input  logic [31:0]             lsb_value,
    output logic                    lsb_ready,
    output logic                    cdb_valid,
    output logic [ROB_SIZE_BIT-1:0] cdb_rob_idx,
    output logic [31:0]             cdb_value,
    output logic                    cdb_src
);

    import cdb_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ROB_SIZE_BIT + CDB_VALUE_W;

    logic [ENTRY_W-1:0] alu_head, lsb_head;
    logic [ENTRY_W-1:0] alu_sel_p0, lsb_sel_p0;
    logic [CNT_W-1:0]   alu_count, lsb_count;
    logic               alu_full, lsb_full;
    logic               alu_empty, lsb_empty;
    logic               advance_p0;
    logic               alu_accept_p0, lsb_accept_p0;
    logic               alu_req_p0, lsb_req_p0;
    logic               gnt_alu_p0, gnt_lsb_p0;
    logic               alu_bypass_p0, lsb_bypass_p0;
    logic               alu_push_p0, lsb_push_p0;
    logic               alu_pop_p0, lsb_pop_p0;
    logic               last_grant;

    logic                    vld_p1;
    logic [ROB_SIZE_BIT-1:0] rob_idx_p1;
    logic [31:0]             value_p1;
    logic                    src_p1;

    // ---- stage p0: accept, request, round-robin grant ----
    assign advance_p0    = rdy_in && !rob_clear;
    assign alu_ready     = !alu_full;
    assign lsb_ready     = !lsb_full;
    assign alu_accept_p0 = alu_valid && alu_ready && advance_p0;
    assign lsb_accept_p0 = lsb_valid && lsb_ready && advance_p0;
    assign alu_empty     = (alu_count == '0);
    assign lsb_empty     = (lsb_count == '0);

`ifdef CDB_BYPASS_EN
    // A fresh result at an empty FIFO competes as if it were already queued.
    assign alu_req_p0    = !alu_empty || alu_accept_p0;
    assign lsb_req_p0    = !lsb_empty || lsb_accept_p0;
    assign alu_bypass_p0 = gnt_alu_p0 && alu_empty;
    assign lsb_bypass_p0 = gnt_lsb_p0 && lsb_empty;
`else
    assign alu_req_p0    = !alu_empty;
    assign lsb_req_p0    = !lsb_empty;
    assign alu_bypass_p0 = 1'b0;
    assign lsb_bypass_p0 = 1'b0;
`endif

    always_comb begin
        gnt_alu_p0 = 1'b0;
        gnt_lsb_p0 = 1'b0;
        if (advance_p0) begin
            if (alu_req_p0 && lsb_req_p0) begin
                // Tie: the side that did not win last time goes first.
                if (last_grant == CDB_SRC_LSB) gnt_alu_p0 = 1'b1;
                else                           gnt_lsb_p0 = 1'b1;
            end else if (alu_req_p0) begin
                gnt_alu_p0 = 1'b1;
            end else if (lsb_req_p0) begin
                gnt_lsb_p0 = 1'b1;
            end
        end
    end

    // A bypassed result never touches the FIFO; a losing arrival is stored.
    assign alu_push_p0 = alu_accept_p0 && !alu_bypass_p0;
    assign lsb_push_p0 = lsb_accept_p0 && !lsb_bypass_p0;
    assign alu_pop_p0  = gnt_alu_p0 && !alu_bypass_p0;
    assign lsb_pop_p0  = gnt_lsb_p0 && !lsb_bypass_p0;

    assign alu_sel_p0 = alu_bypass_p0 ? {alu_rob_idx, alu_value} : alu_head;
    assign lsb_sel_p0 = lsb_bypass_p0 ? {lsb_rob_idx, lsb_value} : lsb_head;

    cdb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (ENTRY_W)
    ) u_alu_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .en        (rdy_in),
        .push      (alu_push_p0),
        .pop       (alu_pop_p0),
        .flush     (rob_clear),
        .push_data ({alu_rob_idx, alu_value}),
        .head      (alu_head),
        .count     (alu_count),
        .full      (alu_full)
    );

    cdb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (ENTRY_W)
    ) u_lsb_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .en        (rdy_in),
        .push      (lsb_push_p0),
        .pop       (lsb_pop_p0),
        .flush     (rob_clear),
        .push_data ({lsb_rob_idx, lsb_value}),
        .head      (lsb_head),
        .count     (lsb_count),
        .full      (lsb_full)
    );

    // ---- stage p1: registered CDB broadcast ----
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_p1     <= 1'b0;
            rob_idx_p1 <= '0;
            value_p1   <= '0;
            src_p1     <= CDB_SRC_ALU;
            last_grant <= CDB_SRC_LSB;
        end else if (rdy_in) begin
            if (rob_clear) begin
                vld_p1     <= 1'b0;
                last_grant <= CDB_SRC_LSB;
            end else if (gnt_alu_p0 || gnt_lsb_p0) begin
                vld_p1                 <= 1'b1;
                {rob_idx_p1, value_p1} <= gnt_alu_p0 ? alu_sel_p0 : lsb_sel_p0;
                src_p1                 <= gnt_alu_p0 ? CDB_SRC_ALU : CDB_SRC_LSB;
                last_grant             <= gnt_alu_p0 ? CDB_SRC_ALU : CDB_SRC_LSB;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign cdb_valid   = vld_p1;
    assign cdb_rob_idx = rob_idx_p1;
    assign cdb_value   = value_p1;
    assign cdb_src     = src_p1;

endmodule
